// File: rtl/entropy_src_pkg.sv
`default_nettype none
// ============================================================================
// Module   : entropy_src_pkg
// Purpose  : Shared types for the repetitive-count alert tracker: sparse
//            state encoding and a legality helper for fault detection.
// Revision : 1.0 - initial release
// ============================================================================
package entropy_src_pkg;

  localparam int RepcntTrkStateWidth = 6;

  // Pairwise Hamming distance between encodings is at least 3, so a single
  // or double upset can never land on another legal state.
  typedef enum logic [RepcntTrkStateWidth-1:0] {
    RepcntTrkIdle  = 6'b011000,
    RepcntTrkRun   = 6'b100101,
    RepcntTrkAlert = 6'b110010,
    RepcntTrkError = 6'b001111
  } entropy_src_repcnt_trk_e;

  // True when the state register holds one of the four legal encodings.
  function automatic logic repcnt_trk_state_legal(entropy_src_repcnt_trk_e s);
    logic legal;
    legal = 1'b0;
    case (s)
      RepcntTrkIdle, RepcntTrkRun, RepcntTrkAlert, RepcntTrkError: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage
`default_nettype wire

// File: rtl/caliptra_prim_count.sv
`default_nettype none
// ============================================================================
// Module   : caliptra_prim_count
// Purpose  : Hardened counter. An up counter and a complementary down counter
//            advance in lockstep; any disagreement is reported on err_o.
//            No internal saturation: callers gate incr_en_i/decr_en_i.
// Revision : 1.0 - initial release
// ============================================================================
module caliptra_prim_count #(
  parameter int Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             set_i,
  input  logic [Width-1:0] set_cnt_i,
  input  logic             incr_en_i,
  input  logic             decr_en_i,
  input  logic [Width-1:0] step_i,
  output logic [Width-1:0] cnt_o,
  output logic             err_o
);

  logic [Width-1:0] up_cnt_d, up_cnt_q;
  logic [Width-1:0] dn_cnt_d, dn_cnt_q;

  // Next value of both copies; the down copy always tracks ~up.
  always_comb begin
    up_cnt_d = up_cnt_q;
    dn_cnt_d = dn_cnt_q;
    if (clr_i) begin
      up_cnt_d = '0;
      dn_cnt_d = '1;
    end else if (set_i) begin
      up_cnt_d = set_cnt_i;
      dn_cnt_d = ~set_cnt_i;
    end else if (incr_en_i) begin
      up_cnt_d = up_cnt_q + step_i;
      dn_cnt_d = dn_cnt_q - step_i;
    end else if (decr_en_i) begin
      up_cnt_d = up_cnt_q - step_i;
      dn_cnt_d = dn_cnt_q + step_i;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      up_cnt_q <= '0;
      dn_cnt_q <= '1;
    end else begin
      up_cnt_q <= up_cnt_d;
      dn_cnt_q <= dn_cnt_d;
    end
  end

  assign cnt_o = up_cnt_q;
  assign err_o = (up_cnt_q != ~dn_cnt_q);

endmodule
`default_nettype wire

// File: rtl/entropy_src_watermark_reg.sv
`default_nettype none
// ============================================================================
// Module   : entropy_src_watermark_reg
// Purpose  : High watermark register. Captures value_i when it strictly
//            exceeds the held maximum on a qualifying event.
// Revision : 1.0 - initial release
// ============================================================================
module entropy_src_watermark_reg #(
  parameter int RegWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                event_i,
  input  logic [RegWidth-1:0] value_i,
  output logic [RegWidth-1:0] value_o
);

  logic [RegWidth-1:0] max_d, max_q;

  // Clear wins; otherwise only a strictly larger sample updates the max.
  always_comb begin
    max_d = max_q;
    if (clear_i) begin
      max_d = '0;
    end else if (event_i && (value_i > max_q)) begin
      max_d = value_i;
    end
  end

  // Watermark register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      max_q <= '0;
    end else begin
      max_q <= max_d;
    end
  end

  assign value_o = max_q;

endmodule
`default_nettype wire

// File: rtl/entropy_src_repcnt_alert_tracker.sv
`default_nettype none
// ============================================================================
// Module   : entropy_src_repcnt_alert_tracker
// Purpose  : Post-processes the repetitive-count health test: watermark,
//            saturating fail counters, consecutive-failing-window alert and
//            sticky fatal error on counter or state-register faults.
// Revision : 1.0 - initial release
// ============================================================================
module entropy_src_repcnt_alert_tracker
  import entropy_src_pkg::*;
#(
  parameter int RegWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                active_i,
  input  logic                clear_i,
  input  logic [RegWidth-1:0] test_cnt_i,
  input  logic                test_fail_pulse_i,
  input  logic                count_err_i,
  input  logic                window_wrap_pulse_i,
  input  logic [RegWidth-1:0] alert_thresh_i,
  output logic [RegWidth-1:0] watermark_o,
  output logic [RegWidth-1:0] total_fail_cnt_o,
  output logic [RegWidth-1:0] consec_fail_cnt_o,
  output logic                recov_alert_o,
  output logic                alert_active_o,
  output logic                fatal_err_o
);

  localparam logic [RegWidth-1:0] StepOne = RegWidth'(1);

  entropy_src_repcnt_trk_e state_d, state_q;
  logic recov_alert_d, recov_alert_q;
  logic alert_active_d, alert_active_q;
  logic fatal_err_d, fatal_err_q;
  logic win_fail_d, win_fail_q;

  logic clr;
  logic cnt_en;
  logic win_failed;
  logic thresh_hit;

  logic [RegWidth-1:0] tot_cnt;
  logic                tot_incr;
  logic                tot_err;

  logic [RegWidth-1:0] consec_cnt;
  logic [RegWidth-1:0] consec_cnt_d;
  logic                consec_incr;
  logic                consec_set;
  logic                consec_err;

  // Dropping active behaves exactly like a software clear.
  assign clr    = clear_i | ~active_i;
  assign cnt_en = ((state_q == RepcntTrkRun) || (state_q == RepcntTrkAlert)) & ~clr;

  // A fail pulse coincident with the wrap belongs to the window that ends.
  assign win_failed = win_fail_q | test_fail_pulse_i;

  // Counter controls; increments are suppressed at all-ones to saturate.
  assign tot_incr    = cnt_en & test_fail_pulse_i & ~(&tot_cnt);
  assign consec_incr = cnt_en & window_wrap_pulse_i & win_failed & ~(&consec_cnt);
  assign consec_set  = clr | (cnt_en & window_wrap_pulse_i & ~win_failed);

  // Value the consecutive counter takes at the coming edge, used for the
  // threshold comparison so the alert fires on the wrap that reaches it.
  always_comb begin
    consec_cnt_d = consec_cnt;
    if (consec_set) begin
      consec_cnt_d = '0;
    end else if (consec_incr) begin
      consec_cnt_d = consec_cnt + StepOne;
    end
  end

  assign thresh_hit = cnt_en & window_wrap_pulse_i & (alert_thresh_i != '0) &
                      (consec_cnt_d >= alert_thresh_i);

  caliptra_prim_count #(
    .Width (RegWidth)
  ) u_total_fail_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (1'b0),
    .set_i     (clr),
    .set_cnt_i ('0),
    .incr_en_i (tot_incr),
    .decr_en_i (1'b0),
    .step_i    (StepOne),
    .cnt_o     (tot_cnt),
    .err_o     (tot_err)
  );

  caliptra_prim_count #(
    .Width (RegWidth)
  ) u_consec_fail_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (1'b0),
    .set_i     (consec_set),
    .set_cnt_i ('0),
    .incr_en_i (consec_incr),
    .decr_en_i (1'b0),
    .step_i    (StepOne),
    .cnt_o     (consec_cnt),
    .err_o     (consec_err)
  );

  entropy_src_watermark_reg #(
    .RegWidth (RegWidth)
  ) u_watermark (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clr),
    .event_i (cnt_en),
    .value_i (test_cnt_i),
    .value_o (watermark_o)
  );

  // Window-fail flag: set by a pulse, dropped at every window boundary.
  always_comb begin
    win_fail_d = win_fail_q;
    if (clr) begin
      win_fail_d = 1'b0;
    end else if (cnt_en) begin
      if (window_wrap_pulse_i) begin
        win_fail_d = 1'b0;
      end else if (test_fail_pulse_i) begin
        win_fail_d = 1'b1;
      end
    end
  end

  // Window-fail flag register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_fail_q <= 1'b0;
    end else begin
      win_fail_q <= win_fail_d;
    end
  end

  // Next state and registered outputs; ERROR and illegal codes never escape.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RepcntTrkIdle: begin
        if (!clr) state_d = RepcntTrkRun;
      end
      RepcntTrkRun: begin
        if (clr)             state_d = RepcntTrkIdle;
        else if (thresh_hit) state_d = RepcntTrkAlert;
      end
      RepcntTrkAlert: begin
        if (clr) state_d = RepcntTrkIdle;
      end
      RepcntTrkError: begin
        state_d = RepcntTrkError;
      end
      default: begin
        state_d = RepcntTrkError;
      end
    endcase

    recov_alert_d  = (state_q == RepcntTrkRun) && (state_d == RepcntTrkAlert);
    alert_active_d = (state_d == RepcntTrkAlert);
    fatal_err_d    = fatal_err_q | count_err_i | tot_err | consec_err |
                     ~repcnt_trk_state_legal(state_q) |
                     (state_q == RepcntTrkError);
  end

  // FSM state and its registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= RepcntTrkIdle;
      recov_alert_q  <= 1'b0;
      alert_active_q <= 1'b0;
      fatal_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      recov_alert_q  <= recov_alert_d;
      alert_active_q <= alert_active_d;
      fatal_err_q    <= fatal_err_d;
    end
  end

  assign total_fail_cnt_o  = tot_cnt;
  assign consec_fail_cnt_o = consec_cnt;
  assign recov_alert_o     = recov_alert_q;
  assign alert_active_o    = alert_active_q;
  assign fatal_err_o       = fatal_err_q;

endmodule
`default_nettype wire

// File: tb/tb_entropy_src_repcnt_alert_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_entropy_src_repcnt_alert_tracker
// Purpose  : Scoreboard bench for the repetitive-count alert tracker. The
//            driver pushes expected output values tagged with the cycle they
//            must appear; an independent monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_entropy_src_repcnt_alert_tracker;
  import entropy_src_pkg::*;

  localparam int W = 4;

  localparam int SelWm     = 0;
  localparam int SelTot    = 1;
  localparam int SelConsec = 2;
  localparam int SelRecov  = 3;
  localparam int SelActive = 4;
  localparam int SelFatal  = 5;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         active_i = 1'b0;
  logic         clear_i = 1'b0;
  logic [W-1:0] test_cnt_i = '0;
  logic         test_fail_pulse_i = 1'b0;
  logic         count_err_i = 1'b0;
  logic         window_wrap_pulse_i = 1'b0;
  logic [W-1:0] alert_thresh_i = '0;
  logic [W-1:0] watermark_o;
  logic [W-1:0] total_fail_cnt_o;
  logic [W-1:0] consec_fail_cnt_o;
  logic         recov_alert_o;
  logic         alert_active_o;
  logic         fatal_err_o;

  entropy_src_repcnt_alert_tracker #(
    .RegWidth (W)
  ) dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .active_i            (active_i),
    .clear_i             (clear_i),
    .test_cnt_i          (test_cnt_i),
    .test_fail_pulse_i   (test_fail_pulse_i),
    .count_err_i         (count_err_i),
    .window_wrap_pulse_i (window_wrap_pulse_i),
    .alert_thresh_i      (alert_thresh_i),
    .watermark_o         (watermark_o),
    .total_fail_cnt_o    (total_fail_cnt_o),
    .consec_fail_cnt_o   (consec_fail_cnt_o),
    .recov_alert_o       (recov_alert_o),
    .alert_active_o      (alert_active_o),
    .fatal_err_o         (fatal_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int           cyc;
    int           sel;
    logic [W-1:0] val;
    string        name;
  } exp_t;

  exp_t sb_q[$];
  int   cyc     = 0;
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic logic [W-1:0] actual(input int sel);
    logic [W-1:0] v;
    v = '0;
    case (sel)
      SelWm:     v = watermark_o;
      SelTot:    v = total_fail_cnt_o;
      SelConsec: v = consec_fail_cnt_o;
      SelRecov:  v = {{(W-1){1'b0}}, recov_alert_o};
      SelActive: v = {{(W-1){1'b0}}, alert_active_o};
      SelFatal:  v = {{(W-1){1'b0}}, fatal_err_o};
      default:   v = 'x;
    endcase
    return v;
  endfunction

  // Monitor: after every rising edge, compare all expectations due now.
  initial begin
    exp_t e;
    logic [W-1:0] got;
    forever begin
      @(posedge clk_i);
      cyc++;
      #1;
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e   = sb_q.pop_front();
        got = actual(e.sel);
        n_total++;
        if (e.cyc == cyc && got === e.val) begin
          n_pass++;
        end else begin
          $display("FAIL %s (cycle %0d): got %0d, expected %0d", e.name, e.cyc, got, e.val);
        end
      end
    end
  end

  // Expect an output value right after the coming rising edge.
  task automatic chk(input int sel, input logic [W-1:0] val, input string name);
    exp_t e;
    e.cyc  = cyc + 1;
    e.sel  = sel;
    e.val  = val;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic act, input logic clr, input logic fail,
                       input logic wrap, input logic err, input logic [W-1:0] cnt);
    @(negedge clk_i);
    active_i            = act;
    clear_i             = clr;
    test_fail_pulse_i   = fail;
    window_wrap_pulse_i = wrap;
    count_err_i         = err;
    test_cnt_i          = cnt;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Clear, then one active cycle so the tracker is back in RUN.
  task automatic restart();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] wm_in [5];
    logic [W-1:0] wm_ex [5];
    logic [W-1:0] sat;
    wm_in = '{4'd3, 4'd7, 4'd5, 4'd7, 4'd9};
    wm_ex = '{4'd3, 4'd7, 4'd7, 4'd7, 4'd9};

    // Reset values.
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    n_total++;
    if (watermark_o !== '0) begin
      $display("FAIL direct_reset_wm: got %0d, expected 0", watermark_o);
    end else begin
      n_pass++;
    end
    n_total++;
    if (total_fail_cnt_o !== '0) begin
      $display("FAIL direct_reset_tot: got %0d, expected 0", total_fail_cnt_o);
    end else begin
      n_pass++;
    end
    n_total++;
    if (fatal_err_o !== 1'b0) begin
      $display("FAIL direct_reset_fatal: got %0d, expected 0", fatal_err_o);
    end else begin
      n_pass++;
    end
    chk(SelWm, 0, "reset_wm");
    chk(SelTot, 0, "reset_tot");
    chk(SelConsec, 0, "reset_consec");
    chk(SelRecov, 0, "reset_recov");
    chk(SelActive, 0, "reset_active");
    chk(SelFatal, 0, "reset_fatal");
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle();

    // Watermark tracking and clear.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, wm_in[i]);
      chk(SelWm, wm_ex[i], "watermark");
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk(SelWm, 0, "wm_clear");
    idle();

    // Alert at threshold 2, no re-fire on a third failing window.
    alert_thresh_i = 4'd2;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk(SelTot, 1, "alert_tot1");
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    chk(SelConsec, 1, "alert_consec1");
    chk(SelRecov, 0, "alert_no_recov1");
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk(SelTot, 2, "alert_tot2");
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    chk(SelConsec, 2, "alert_consec2");
    chk(SelRecov, 1, "alert_recov_pulse");
    chk(SelActive, 1, "alert_active");
    idle();
    chk(SelRecov, 0, "alert_recov_single");
    chk(SelActive, 1, "alert_active_held");
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    chk(SelConsec, 3, "alert_consec3");
    chk(SelRecov, 0, "alert_no_refire");

    // One inactive cycle drops the alert and clears counters.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk(SelActive, 0, "inactive_active");
    chk(SelConsec, 0, "inactive_consec");
    chk(SelTot, 0, "inactive_tot");
    idle();

    // Threshold 3: fail, pass, fail, then coincident pulse+wrap.
    alert_thresh_i = 4'd3;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk(SelTot, 1, "pat_tot1");
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    chk(SelConsec, 1, "pat_consec_fail");
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    chk(SelConsec, 0, "pat_consec_pass");
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    chk(SelConsec, 1, "pat_consec_fail2");
    chk(SelActive, 0, "pat_no_alert");
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    chk(SelConsec, 2, "coinc_consec");
    chk(SelTot, 3, "coinc_tot");
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    chk(SelConsec, 0, "coinc_no_carry");
    chk(SelActive, 0, "coinc_no_alert");

    // Saturation with alert disabled.
    restart();
    alert_thresh_i = '0;
    for (int i = 0; i < 20; i++) begin
      sat = (i + 1 > 15) ? 4'd15 : W'(i + 1);
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, '0);
      chk(SelTot, sat, "sat_tot");
      chk(SelConsec, sat, "sat_consec");
      chk(SelActive, 0, "sat_no_alert");
    end
    idle();
    chk(SelTot, 15, "sat_tot_hold");
    chk(SelRecov, 0, "sat_no_recov");

    // Clear beats same-cycle pulse, wrap and count; tracker then idles.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6);
    chk(SelWm, 6, "prio_wm_pre");
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd5);
    chk(SelWm, 0, "prio_wm");
    chk(SelTot, 0, "prio_tot");
    chk(SelConsec, 0, "prio_consec");
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk(SelTot, 0, "prio_idle_no_count");
    idle();

    // Fatal from count_err_i: sticky through clear, removed by reset.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    chk(SelFatal, 1, "fatal_set");
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk(SelFatal, 1, "fatal_thru_clear");
    idle();
    chk(SelFatal, 1, "fatal_held");
    n_total++;
    if (fatal_err_o !== 1'b1) begin
      $display("FAIL direct_fatal_held: got %0d, expected 1", fatal_err_o);
    end else begin
      n_pass++;
    end
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    n_total++;
    if (fatal_err_o !== 1'b0) begin
      $display("FAIL direct_fatal_async_reset: got %0d, expected 0", fatal_err_o);
    end else begin
      n_pass++;
    end
    chk(SelFatal, 0, "fatal_reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle();
    chk(SelFatal, 0, "fatal_after_reset");

    // Illegal state encoding.
    @(negedge clk_i);
    force dut.state_q = entropy_src_repcnt_trk_e'(6'b000000);
    chk(SelFatal, 1, "fatal_illegal_state");
    @(negedge clk_i);
    release dut.state_q;
    chk(SelFatal, 1, "fatal_illegal_held");
    chk(SelActive, 0, "illegal_no_alert");
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk(SelFatal, 1, "error_holds_clear");

    repeat (3) @(negedge clk_i);
    while (sb_q.size() > 0) begin
      n_total++;
      $display("FAIL unchecked_%s: got no sample, expected value %0d", sb_q[0].name, sb_q[0].val);
      void'(sb_q.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
